// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
//   Round-robin arbiter sharing the single push port of a valid/ready FIFO
//   among NUM_REQ requesters. A winner is picked in IDLE (one cycle of
//   arbitration latency) and its stream is then forwarded combinationally
//   to the FIFO for up to MAX_BURST beats. The grant ends after the last
//   burst beat or as soon as the granted requester drops valid. The
//   priority pointer then moves one step past the released requester.
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        synchronous active-low reset
//   req_data_i    requester data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_valid_i   per-requester valid
//   req_ready_o   per-requester ready (only the granted bit can be high)
//   fifo_data_o   data towards the FIFO input
//   fifo_valid_o  valid towards the FIFO input
//   fifo_ready_i  ready from the FIFO input
//   grant_id_o    current or last granted requester index
//   busy_o        high while a grant is active
module fifo_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          fifo_valid_o,
  input  logic                          fifo_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          busy_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic                  sel_found;
  logic [IDW-1:0]        sel_idx;
  logic                  gnt_valid;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  hs;
  logic                  last_beat;
  logic [IDW-1:0]        gnt_next;

  // Round-robin pick: candidates are visited in the order ptr, ptr+1, ...
  // (wrapping), and the first valid one wins. The inner loop keeps every
  // vector index a constant.
  always_comb begin
    int cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!sel_found && (cand == k) && req_valid_i[k]) begin
          sel_found = 1'b1;
          sel_idx   = IDW'(k);
        end
      end
    end
  end

  // Select the granted requester's valid and data.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_q == IDW'(k)) begin
        gnt_valid = req_valid_i[k];
        gnt_data  = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign hs        = gnt_valid & fifo_ready_i;
  assign last_beat = (cnt_q == CW'(MAX_BURST - 1));
  assign gnt_next  = (gnt_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_q + IDW'(1);
  assign grant_id_o = gnt_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    req_ready_o  = '0;
    fifo_valid_o = 1'b0;
    fifo_data_o  = '0;
    busy_o       = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          gnt_d   = sel_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        busy_o       = 1'b1;
        fifo_valid_o = gnt_valid;
        fifo_data_o  = gnt_data;
        for (int k = 0; k < NUM_REQ; k++) begin
          req_ready_o[k] = (gnt_q == IDW'(k)) & fifo_ready_i;
        end
        if (hs) cnt_d = cnt_q + CW'(1);
        // A final beat and a valid drop in the same cycle still release
        // only once, so the pointer moves exactly one step past gnt.
        if ((hs && last_beat) || !gnt_valid) begin
          state_d = IDLE;
          ptr_d   = gnt_next;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // No handshake may complete in a cycle that is being reset.
    if (!rst_ni) begin
      req_ready_o  = '0;
      fifo_valid_o = 1'b0;
      busy_o       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
module tb_fifo_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk;
  logic            rst_n;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   fifo_data;
  logic            fifo_valid;
  logic            fifo_ready;
  logic [1:0]      grant_id;
  logic            busy;

  // Second instance with single-beat bursts.
  logic [N*DW-1:0] req1_data;
  logic [N-1:0]    req1_valid;
  logic [N-1:0]    req1_ready;
  logic [DW-1:0]   fifo1_data;
  logic            fifo1_valid;
  logic            fifo1_ready;
  logic [1:0]      grant1_id;
  logic            busy1;

  fifo_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_data_i(req_data), .req_valid_i(req_valid),
    .req_ready_o(req_ready), .fifo_data_o(fifo_data), .fifo_valid_o(fifo_valid),
    .fifo_ready_i(fifo_ready), .grant_id_o(grant_id), .busy_o(busy)
  );

  fifo_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_data_i(req1_data), .req_valid_i(req1_valid),
    .req_ready_o(req1_ready), .fifo_data_o(fifo1_data), .fifo_valid_o(fifo1_valid),
    .fifo_ready_i(fifo1_ready), .grant_id_o(grant1_id), .busy_o(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         id;
    logic [7:0] d;
  } beat_t;
  beat_t sb[$];

  // Reference model of the main instance: who holds the grant, how many
  // beats it has moved, and where the round-robin scan starts next.
  bit m_busy = 0;
  int m_gnt  = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", {31'd0, fifo_valid}, 0);
      chk("rst_ready", {28'd0, req_ready}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      m_busy = 0; m_gnt = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      logic [N-1:0] exp_rdy;
      exp_rdy = '0;
      if (m_busy) exp_rdy[m_gnt] = fifo_ready;
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("grant_id", {30'd0, grant_id}, m_gnt);
      chk("fifo_valid", {31'd0, fifo_valid}, m_busy ? {31'd0, req_valid[m_gnt]} : 0);
      chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
      if (!m_busy) begin
        for (int i = 0; i < N; i++) begin
          int idx;
          idx = (m_ptr + i) % N;
          if (req_valid[idx]) begin
            m_gnt = idx; m_busy = 1; m_cnt = 0;
            break;
          end
        end
      end else begin
        bit v;
        v = req_valid[m_gnt];
        if (v && fifo_ready) begin
          beat_t b;
          b.id = m_gnt;
          b.d  = req_data[m_gnt*DW +: DW];
          sb.push_back(b);
          m_cnt++;
        end
        if ((v && fifo_ready && m_cnt == MB) || !v) begin
          m_busy = 0;
          m_ptr  = (m_gnt + 1) % N;
          m_cnt  = 0;
        end
      end
    end
  end

  // Monitor: whenever the DUT completes a push, it must match the oldest
  // beat the model expects.
  always @(negedge clk) begin
    #1;
    if (fifo_valid && fifo_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_push actual=%0h required=none at %0t", fifo_data, $time);
      end else begin
        beat_t b;
        b = sb.pop_front();
        chk("push_data", {24'd0, fifo_data}, {24'd0, b.d});
        chk("push_id", {30'd0, grant_id}, b.id);
      end
    end
  end

  logic [N-1:0] hs;
  int p_v, p_r;

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    fifo_ready  = 1'b1;
    req1_valid  = '0;
    req1_data   = '0;
    fifo1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single-beat bursts with requesters 0 and 3: grants alternate 0,3,0,3
    // with an idle cycle between each, and the pointer wraps 3 -> 0.
    req1_valid = 4'b1001;
    req1_data  = $urandom;
    for (int i = 0; i < 10; i++) begin
      int eid;
      @(negedge clk);
      eid = (((i - 1) / 2) % 2 == 1) ? 3 : 0;
      chk("mb1_busy", {31'd0, busy1}, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 1) begin
        chk("mb1_gid", {30'd0, grant1_id}, eid);
        chk("mb1_valid", {31'd0, fifo1_valid}, 1);
        chk("mb1_data", {24'd0, fifo1_data}, {24'd0, req1_data[eid*DW +: DW]});
      end else begin
        chk("mb1_idle_valid", {31'd0, fifo1_valid}, 0);
      end
      @(posedge clk);
      #1 req1_data = $urandom;
    end
    req1_valid = '0;

    // Randomised traffic in phases of differing request and backpressure
    // density, with occasional one-cycle resets landing mid-burst.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      case ((cyc / 500) % 6)
        0: begin p_v = 100; p_r = 100; end
        1: begin p_v = 30;  p_r = 100; end
        2: begin p_v = 90;  p_r = 40;  end
        3: begin p_v = 60;  p_r = 80;  end
        4: begin p_v = 100; p_r = 20;  end
        default: begin p_v = 15; p_r = 70; end
      endcase
      rst_n = ((cyc % 397) == 200) ? 1'b0 : 1'b1;
      for (int k = 0; k < N; k++) begin
        if (!(req_valid[k] && !hs[k])) begin
          if ($urandom_range(99) < p_v) begin
            req_valid[k]            = 1'b1;
            req_data[k*DW +: DW]    = DW'($urandom);
          end else begin
            req_valid[k] = 1'b0;
          end
        end
      end
      fifo_ready = ($urandom_range(99) < p_r);
    end

    req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
